// File: rtl/rx_fcs_checker.sv
// rx_fcs_checker: receive frame sequencer and FCS checker.
// Drives an external byte-wide CRC32 engine (MSB-first), checks the final
// engine value against the CRC-32 residue, and reports one status pulse per
// frame. Optional length checking is enabled by RX_FCS_LEN_CHECK_EN.
module rx_fcs_checker #(
    parameter int          MIN_LEN  = 64,
    parameter int          MAX_LEN  = 1518,
    parameter logic [31:0] CRC_SEED = 32'hFFFFFFFF,
    parameter logic [31:0] RESIDUE  = 32'hC704DD7B
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic [7:0]  DATA_IN,
    input  logic        DATA_VALID,
    input  logic        SOF,
    input  logic        EOF,
    output logic        CRC_START,
    output logic        CRC_LOAD,
    output logic [31:0] CRC_INIT,
    output logic [7:0]  CRC_DATA,
    input  logic [31:0] CRC_VALUE,
    output logic        STATUS_VALID,
    output logic        FCS_OK,
    output logic        RUNT,
    output logic        OVERSIZE,
    output logic        SEQ_ERR,
    output logic [15:0] FRAME_LEN
);

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        FRAME = 2'd2,
        CHECK = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] byte_cnt;
    logic        seq_flag;

    logic        sof_byte;
    logic        eof_byte;

    assign sof_byte = DATA_VALID & SOF;
    assign eof_byte = DATA_VALID & EOF;
    assign CRC_INIT = CRC_SEED;

    // Wire bit 0 (first on the wire) to the engine's MSB.
    always_comb begin
        CRC_DATA = '0;
        for (int i = 0; i < 8; i++) begin
            CRC_DATA[7-i] = DATA_IN[i];
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= INIT;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and engine controls; LOAD only in INIT/CHECK, START only in
    // IDLE/FRAME, so the two can never coincide.
    always_comb begin
        state_nxt = state;
        CRC_START = 1'b0;
        CRC_LOAD  = 1'b0;
        case (state)
            INIT: begin
                CRC_LOAD  = 1'b1;
                state_nxt = IDLE;
            end
            IDLE: begin
                if (sof_byte) begin
                    CRC_START = 1'b1;
                    state_nxt = EOF ? CHECK : FRAME;
                end
            end
            FRAME: begin
                CRC_START = DATA_VALID;
                if (eof_byte) begin
                    state_nxt = CHECK;
                end
            end
            CHECK: begin
                CRC_LOAD  = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = INIT;
            end
        endcase
    end

    // Frame byte counter, saturating at all-ones.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            byte_cnt <= '0;
        end else if (state == IDLE && sof_byte) begin
            byte_cnt <= 16'd1;
        end else if (state == FRAME && DATA_VALID && byte_cnt != 16'hFFFF) begin
            byte_cnt <= byte_cnt + 16'd1;
        end
    end

    // Sticky framing-violation flag, reported with the next frame's status.
    // A byte dropped in CHECK belongs to the following frame's report, so it
    // re-sets the flag in the same cycle the old value is consumed.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            seq_flag <= 1'b0;
        end else begin
            case (state)
                IDLE:    if (DATA_VALID && !SOF) seq_flag <= 1'b1;
                FRAME:   if (sof_byte)           seq_flag <= 1'b1;
                CHECK:   seq_flag <= DATA_VALID;
                default: seq_flag <= seq_flag;
            endcase
        end
    end

    // Status registers, captured in CHECK and held until the next capture.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            STATUS_VALID <= 1'b0;
            FCS_OK       <= 1'b0;
            RUNT         <= 1'b0;
            OVERSIZE     <= 1'b0;
            SEQ_ERR      <= 1'b0;
            FRAME_LEN    <= '0;
        end else begin
            STATUS_VALID <= (state == CHECK);
            if (state == CHECK) begin
                FCS_OK    <= (CRC_VALUE == RESIDUE);
                SEQ_ERR   <= seq_flag;
                FRAME_LEN <= byte_cnt;
`ifdef RX_FCS_LEN_CHECK_EN
                RUNT      <= (byte_cnt < 16'(MIN_LEN));
                OVERSIZE  <= (byte_cnt > 16'(MAX_LEN));
`else
                RUNT      <= 1'b0;
                OVERSIZE  <= 1'b0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_rx_fcs_checker.sv
// Directed bench for rx_fcs_checker with a behavioural MSB-first CRC32
// engine and an independent reflected CRC-32 used to build frame FCS.
module tb_rx_fcs_checker;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic [7:0]  DATA_IN;
    logic        DATA_VALID, SOF, EOF;
    logic        CRC_START, CRC_LOAD;
    logic [31:0] CRC_INIT;
    logic [7:0]  CRC_DATA;
    logic [31:0] CRC_VALUE;
    logic        STATUS_VALID, FCS_OK, RUNT, OVERSIZE, SEQ_ERR;
    logic [15:0] FRAME_LEN;

    rx_fcs_checker dut (
        .CLK(CLK), .RESET_N(RESET_N), .DATA_IN(DATA_IN), .DATA_VALID(DATA_VALID),
        .SOF(SOF), .EOF(EOF), .CRC_START(CRC_START), .CRC_LOAD(CRC_LOAD),
        .CRC_INIT(CRC_INIT), .CRC_DATA(CRC_DATA), .CRC_VALUE(CRC_VALUE),
        .STATUS_VALID(STATUS_VALID), .FCS_OK(FCS_OK), .RUNT(RUNT),
        .OVERSIZE(OVERSIZE), .SEQ_ERR(SEQ_ERR), .FRAME_LEN(FRAME_LEN)
    );

    always #5 CLK = ~CLK;

`ifdef RX_FCS_LEN_CHECK_EN
    localparam bit LEN_EN = 1'b1;
`else
    localparam bit LEN_EN = 1'b0;
`endif

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", tag, act, exp);
        end
    endtask

    // Behavioural CRC engine: non-reflected CRC32, data MSB first.
    function automatic logic [31:0] eng_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 7; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    logic [31:0] eng_crc;
    always @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)       eng_crc <= 32'hFFFFFFFF;
        else if (CRC_LOAD)  eng_crc <= CRC_INIT;
        else if (CRC_START) eng_crc <= eng_step(eng_crc, CRC_DATA);
    end
    assign CRC_VALUE = eng_crc;

    // Cycle counter and status monitor.
    int cyc = 0;
    always @(posedge CLK) cyc++;

    typedef struct {
        logic        ok, runt, over, seq;
        logic [15:0] len;
        int          c;
    } st_t;
    st_t st_q[$];
    int  eof_q[$];

    always @(negedge CLK) begin
        if (STATUS_VALID) begin
            st_t s;
            s.ok = FCS_OK; s.runt = RUNT; s.over = OVERSIZE; s.seq = SEQ_ERR;
            s.len = FRAME_LEN; s.c = cyc;
            st_q.push_back(s);
        end
        if (CRC_LOAD && CRC_START) chk("load_start_excl", 32'(CRC_START), 32'd0);
    end

    // Frame buffer and helpers.
    logic [7:0] frm [0:2047];

    // Standard reflected CRC-32 over frm[0..n-1].
    function automatic logic [31:0] ref_crc(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'd0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    // Random payload of n-4 bytes at offset off, FCS appended LSB first.
    task automatic build_good(input int off, input int n);
        logic [31:0] f;
        logic [7:0]  tmp [0:2047];
        for (int i = 0; i < n - 4; i++) tmp[i] = 8'($urandom);
        for (int i = 0; i < n - 4; i++) frm[i] = tmp[i];
        f = ref_crc(n - 4);
        for (int i = 0; i < n - 4; i++) frm[off + i] = tmp[i];
        frm[off + n - 4] = f[7:0];
        frm[off + n - 3] = f[15:8];
        frm[off + n - 2] = f[23:16];
        frm[off + n - 1] = f[31:24];
    endtask

    task automatic drive_byte(input logic [7:0] d, input logic s, input logic e);
        @(posedge CLK); #1;
        DATA_IN = d; DATA_VALID = 1'b1; SOF = s; EOF = e;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            DATA_VALID = 1'b0; SOF = 1'b0; EOF = 1'b0;
        end
    endtask

    // Send frm[0..n-1]; optional SOF at index sof2; random gaps when gap!=0.
    task automatic send(input int n, input int sof2, input bit gap);
        for (int i = 0; i < n; i++) begin
            if (gap && i > 0 && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            drive_byte(frm[i], (i == 0) || (i == sof2), i == n - 1);
        end
        eof_q.push_back(cyc);
    endtask

    task automatic expect_st(input string tag, input logic ok, input logic runt,
                             input logic over, input logic seq, input int len);
        int n;
        st_t s;
        int e;
        n = 0;
        while (st_q.size() == 0 && n < 40) begin
            @(posedge CLK);
            n++;
        end
        if (st_q.size() == 0) begin
            chk({tag, "_timeout"}, 32'd0, 32'd1);
            if (eof_q.size() > 0) void'(eof_q.pop_front());
        end else begin
            s = st_q.pop_front();
            e = (eof_q.size() > 0) ? eof_q.pop_front() : -100;
            chk({tag, "_lat"},  32'(s.c - e), 32'd2);
            chk({tag, "_ok"},   32'(s.ok),    32'(ok));
            chk({tag, "_runt"}, 32'(s.runt),  32'(runt));
            chk({tag, "_over"}, 32'(s.over),  32'(over));
            chk({tag, "_seq"},  32'(s.seq),   32'(seq));
            chk({tag, "_len"},  32'(s.len),   32'(len));
        end
    endtask

    initial begin
        RESET_N = 1'b0; DATA_IN = 8'h00; DATA_VALID = 1'b0; SOF = 1'b0; EOF = 1'b0;
        repeat (3) @(posedge CLK);
        #1;
        // Reset state and combinational paths.
        chk("rst_load",  32'(CRC_LOAD),     32'd1);
        chk("rst_start", 32'(CRC_START),    32'd0);
        chk("rst_sv",    32'(STATUS_VALID), 32'd0);
        chk("rst_len",   32'(FRAME_LEN),    32'd0);
        chk("crc_init",  CRC_INIT,          32'hFFFFFFFF);
        DATA_IN = 8'h01; #1;
        chk("rev_01", 32'(CRC_DATA), 32'h80);
        DATA_IN = 8'h35; #1;
        chk("rev_35", 32'(CRC_DATA), 32'hAC);
        @(posedge CLK); #1;
        RESET_N = 1'b1;
        chk("init_load", 32'(CRC_LOAD), 32'd1);
        @(posedge CLK); #1;
        chk("idle_load", 32'(CRC_LOAD), 32'd0);

        // Good runt frame: "123456789" + CBF43926 LSB first.
        begin
            logic [7:0] v [0:12];
            v = '{8'h31,8'h32,8'h33,8'h34,8'h35,8'h36,8'h37,8'h38,8'h39,
                  8'h26,8'h39,8'hF4,8'hCB};
            for (int i = 0; i < 13; i++) frm[i] = v[i];
        end
        send(13, -1, 0); idle(1);
        expect_st("runt_good", 1, LEN_EN, 0, 0, 13);

        frm[12] = 8'hCA;
        idle(2); send(13, -1, 0); idle(1);
        expect_st("runt_bad", 0, LEN_EN, 0, 0, 13);

        // Minimum size with random gaps.
        build_good(0, 64);
        idle(2); send(64, -1, 1); idle(1);
        expect_st("min64", 1, 0, 0, 0, 64);

        // Length boundaries.
        build_good(0, 1518);
        idle(2); send(1518, -1, 0); idle(1);
        expect_st("max1518", 1, 0, 0, 0, 1518);
        build_good(0, 1519);
        idle(2); send(1519, -1, 0); idle(1);
        expect_st("over1519", 1, 0, LEN_EN, 0, 1519);

        // Back-to-back: SOF at t+2 accepted.
        build_good(0, 64);
        idle(2); send(64, -1, 0); idle(1); send(64, -1, 0);
        // Byte in CHECK is dropped and flagged on the next frame.
        drive_byte(8'h5A, 1'b0, 1'b0);
        build_good(0, 65);
        send(65, -1, 0); idle(1);
        expect_st("b2b_a", 1, 0, 0, 0, 64);
        expect_st("b2b_b", 1, 0, 0, 0, 64);
        expect_st("b2b_chk_byte", 1, 0, 0, 1, 65);

        // Stray byte in IDLE flags the next frame.
        idle(2); drive_byte(8'h77, 1'b0, 1'b0); idle(2);
        build_good(0, 64);
        send(64, -1, 0); idle(1);
        expect_st("idle_stray", 1, 0, 0, 1, 64);

        // SOF at byte 10 of a 70-byte frame; the trailing 61 bytes are a good
        // frame of their own, so the whole 70 bytes fail the FCS check.
        build_good(9, 61);
        for (int i = 0; i < 9; i++) frm[i] = 8'(8'hA0 + i);
        idle(2); send(70, 9, 0); idle(1);
        expect_st("mid_sof", 0, 0, 0, 1, 70);

        // Reset mid-frame.
        build_good(0, 64);
        idle(2);
        for (int i = 0; i < 30; i++) drive_byte(frm[i], i == 0, 1'b0);
        @(posedge CLK); #1;
        RESET_N = 1'b0; SOF = 1'b1; DATA_VALID = 1'b1;
        #1;
        chk("mrst_seq",   32'(SEQ_ERR),   32'd0);
        chk("mrst_ok",    32'(FCS_OK),    32'd0);
        chk("mrst_len",   32'(FRAME_LEN), 32'd0);
        chk("mrst_start", 32'(CRC_START), 32'd0);
        chk("mrst_load",  32'(CRC_LOAD),  32'd1);
        idle(2);
        RESET_N = 1'b1;
        idle(6);
        chk("mrst_nostat", 32'(st_q.size()), 32'd0);
        build_good(0, 64);
        send(64, -1, 1); idle(1);
        expect_st("post_rst", 1, 0, 0, 0, 64);

        idle(4);
        chk("no_extra_stat", 32'(st_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
